// File: rtl/dsp_pkg.sv
// Shared DSP-path constants and helpers for accumulator sizing and
// magnitude extraction.
package dsp_pkg;
  localparam int ACC_W     = 40;
  localparam int OUT_W     = 16;
  localparam int SHIFT_W   = 5;
  localparam int SHIFT_MAX = 24;

  // One's-complement magnitude: cannot overflow at the most negative value.
  function automatic logic [ACC_W-1:0] mag_of(input logic [ACC_W-1:0] acc);
    return acc[ACC_W-1] ? ~acc : acc;
  endfunction
endpackage

// File: rtl/msb_detect.sv
// Combinational leading-one detector over an accumulator-width word.
module msb_detect
  import dsp_pkg::*;
(
  input  logic [ACC_W-1:0] value,
  output logic [5:0]       index,
  output logic             any
);

  always_comb begin
    index = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (value[i]) index = 6'(i);
    end
  end

  assign any = |value;

endmodule

// File: rtl/auto_shift.sv
// Block-floating-point gain controller: per-frame peak tracking with immediate
// attack and hold-counter-gated decay of the shifter right-shift amount.
module auto_shift
  import dsp_pkg::*;
#(
  parameter int FRAME     = 256,
  parameter int HOLD      = 4,
  parameter int MIN_SHIFT = 0,
  parameter int MAX_SHIFT = SHIFT_MAX
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [ACC_W-1:0]   in,
  output logic [SHIFT_W-1:0] shift,
  output logic               shift_valid,
  output logic               clip
);

  localparam int CNT_W  = $clog2(FRAME);
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  logic [CNT_W-1:0]   frame_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [ACC_W-1:0]   acc_or;
  logic               clip_st;
  logic [ACC_W-1:0]   snap;
  logic               clip_snap;
  logic               snap_vld;
  logic [SHIFT_W-1:0] target;
  logic               clip_tgt;
  logic               tgt_vld;

  logic [ACC_W-1:0]   mag;
  logic [5:0]         chk_amt;
  logic               ovf;
  logic               accept;
  logic               last;
  logic [5:0]         msb_idx;
  logic               msb_any;
  logic [SHIFT_W-1:0] tgt_next;

  assign mag     = mag_of(in);
  assign chk_amt = 6'(OUT_W - 1) + 6'(shift);
  assign ovf     = |(mag >> chk_amt);
  assign accept  = en & in_valid;
  assign last    = accept && (frame_cnt == LAST_IDX);

  msb_detect u_msb (
    .value (snap),
    .index (msb_idx),
    .any   (msb_any)
  );

  // A peak below 2^15 needs no shift; otherwise the top bit must land on bit 14.
  always_comb begin
    int rt;
    rt = 0;
    if (msb_any && (msb_idx >= 6'(OUT_W - 1))) rt = int'(msb_idx) - (OUT_W - 2);
    if (rt < MIN_SHIFT) rt = MIN_SHIFT;
    if (rt > MAX_SHIFT) rt = MAX_SHIFT;
    tgt_next = SHIFT_W'(rt);
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      hold_cnt    <= '0;
      acc_or      <= '0;
      clip_st     <= 1'b0;
      snap        <= '0;
      clip_snap   <= 1'b0;
      snap_vld    <= 1'b0;
      target      <= '0;
      clip_tgt    <= 1'b0;
      tgt_vld     <= 1'b0;
      shift       <= SHIFT_W'(MAX_SHIFT);
      shift_valid <= 1'b0;
      clip        <= 1'b0;
    end else begin
      snap_vld    <= last;
      tgt_vld     <= snap_vld;
      shift_valid <= tgt_vld;
      clip        <= tgt_vld & clip_tgt;

      if (last) begin
        snap      <= acc_or | mag;
        clip_snap <= clip_st | ovf;
      end
      if (snap_vld) begin
        target   <= tgt_next;
        clip_tgt <= clip_snap;
      end

      if (!en || last) begin
        frame_cnt <= '0;
        acc_or    <= '0;
        clip_st   <= 1'b0;
      end else if (in_valid) begin
        frame_cnt <= frame_cnt + 1'b1;
        acc_or    <= acc_or | mag;
        clip_st   <= clip_st | ovf;
      end

      if (tgt_vld) begin
        if (target > shift) begin
          shift    <= target;
          hold_cnt <= '0;
        end else if (target == shift) begin
          hold_cnt <= '0;
        end else if (hold_cnt == HOLD_LAST) begin
          shift    <= shift - 1'b1;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
      if (!en) hold_cnt <= '0;
    end
  end

endmodule

// File: doc/auto_shift.md
# auto_shift

Block-floating-point gain controller for the DSP path. Watches the stream of 40-bit signed accumulator values that feed `shifter`, finds the smallest right-shift that keeps every sample of a frame inside 16-bit signed range, and drives the `shifter` shift input. It produces `shift`; `shifter` consumes it. Increases in shift take effect immediately; decreases are held off by a hysteresis counter.

## Interface
- `FRAME`, 256: samples per measurement frame, at least 2.
- `HOLD`, 4: consecutive frames wanting less shift before `shift` is decremented by 1, at least 1.
- `MIN_SHIFT`, 0: lower clamp on `shift`.
- `MAX_SHIFT`, 24: upper clamp on `shift`, at most 24.
- `ck`  in  1  clock; all logic on posedge ck.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  block enable.
- `in_valid`  in  1  `in` carries a sample this cycle.
- `in`  in  40  signed two's-complement accumulator value.
- `shift`  out  5  current shift amount for `shifter`, range MIN_SHIFT..MAX_SHIFT.
- `shift_valid`  out  1  one-cycle pulse at each frame result.
- `clip`  out  1  qualified by `shift_valid`: some sample in the frame overflowed the shift in effect when it was accepted.

## Operation
- Magnitude: mag = in[39] ? ~in : in. This is one's complement, so there is no overflow at -2^39.
- Per accepted sample (en & in_valid):
  - acc_or |= mag.
  - clip_st |= ((mag >> (15+shift)) != 0).
  - frame_cnt increments.
- Last sample of a frame (frame_cnt == FRAME-1), cycle T:
  - snap <= acc_or | mag; clip_snap <= clip_st | this sample's overflow.
  - acc_or, clip_st and frame_cnt are cleared. A sample at T+1 belongs to the next frame.
- Target at T+1: m = index of the highest set bit of snap.
  - If snap < 2^15, target = 0.
  - Otherwise target = m - 14. m ≤ 38, so target ≤ 24.
  - target is then clamped to MIN_SHIFT..MAX_SHIFT.
- Update at T+2, as a function of target against cur (the current `shift`):
  - target > cur: shift <= target; hold_cnt <= 0.
  - target == cur: hold_cnt <= 0.
  - target < cur with hold_cnt == HOLD-1: shift <= cur-1; hold_cnt <= 0.
  - target < cur otherwise: hold_cnt++.
- `shift_valid` pulses at T+2. `clip` = clip_snap during that pulse, and 0 at all other times.
- en low:
  - in_valid is ignored.
  - frame_cnt, acc_or, clip_st and hold_cnt are cleared.
  - `shift` holds its value.
  - A result already in flight (T+1/T+2 stages) completes normally.

## Timing
- Reset values: shift = MAX_SHIFT; shift_valid = 0; clip = 0; all counters, acc_or, snap and stage flags = 0.
- Reset mid-frame discards the partial frame and any in-flight result. No pulse follows reset.
- Latency: last sample at T, then `shift`/`shift_valid`/`clip` at T+2. Full throughput, one sample per cycle, no stall.
- Samples at T+1 and T+2 are overflow-checked against the old shift.
- `shift` changes only on posedge ck. It is stable across the following negedge, where `shifter` samples it.
- Back-to-back frames with FRAME = 2 are supported: result pipeline stages never collide.

## Structure
- Shared package `dsp_pkg`:
  - ACC_W = 40, OUT_W = 16, SHIFT_W = 5, SHIFT_MAX = 24.
  - Function `mag_of(acc)`.
- Sub-module `msb_detect`: ACC_W-bit leading-one detector with outputs index[5:0] and any. Combinational, used in the T+1 stage.
- Top level holds the counters, the OR accumulator, the snapshot, the hold FSM and the output registers.

## Test plan
Bench parameters: FRAME = 4, HOLD = 2, MIN = 0, MAX = 24.
- Reset check: assert rst_n = 0 for 3 cycles, then release. Required: shift = 24, shift_valid = 0, clip = 0; no pulse before 4 samples have been accepted.
- Full-scale samples:
  - Frame of 4 × 0x80_0000_0000: target 24; shift stays 24, pulse with clip = 0.
  - Frame of 4 × 0x00_0000_8000: target 1.
  - Frame of 4 × 0xFF_FFFF_8000 (-32768): target 0.
- Decay: from shift = 24, feed frames of 0x00_0000_7FFF. Required: shift decrements by 1 every 2nd frame (23 after frame 2, 22 after frame 4), reaching 0.
- Attack with clip: from shift = 0, frame {0, 0, 0x00_0001_0000, 0}. Required: 2 cycles after the last sample, shift = 2, shift_valid = 1, clip = 1 for exactly one cycle.
- Hold reset: at shift = 5, frames with targets 3, 5, 3, 3. Required: shift stays 5 through frame 3 and becomes 4 after frame 4.
- en/reset mid-frame:
  - Drop en after 2 samples, then re-enable. Required: the next pulse comes only after 4 further samples; shift is unchanged while en is low.
  - Pull rst_n low at T+1. Required: no pulse; shift = 24.
